mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the 5-stage RISC-V pipeline.
- Serialises accesses so there is exactly one outstanding memory transaction at a time.
- Prioritises data accesses, because they belong to the older instruction, and bounds fetch starvation with a counter.
- Routes each response back to the requester that issued it.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_pick.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// The latched request struct is sized by ARB_AW/ARB_DW; the top defaults its AW/DW to match.
package mem_port_arbiter_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  localparam int ARB_BW = ARB_DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_e;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [ARB_BW-1:0] be;
  } mem_req_s;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Owner choice between fetch and data, with a saturating counter that
// bounds how many data picks can overtake a waiting fetch.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic       d_req,
  input  logic       pick_en,
  output arb_owner_e owner
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          fetch_starved;

  // Data is the older instruction and normally wins; a fetch that has been
  // passed over STARVE_MAX times in a row takes the next pick.
  always_comb begin
    fetch_starved = if_req && (starve_cnt_q == CNT_MAX);
    owner         = (d_req && !fetch_starved) ? OWN_D : OWN_IF;
    starve_cnt_d  = starve_cnt_q;
    if (pick_en) begin
      if ((owner == OWN_D) && if_req) begin
        starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction
// in flight at a time, and steers each response back to its issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = ARB_AW,
  parameter int unsigned DW         = ARB_DW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  mem_req_s   req_q, req_d;
  mem_req_s   pick_req;
  arb_owner_e pick_owner;
  logic       pick_en;
  logic       any_req;
  logic       resp_fire;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .pick_en(pick_en),
    .owner  (pick_owner)
  );

  // Fetch is always a full-word read, so it carries all byte lanes enabled.
  always_comb begin
    pick_req = '0;
    if (pick_owner == OWN_D) begin
      pick_req.we    = d_we;
      pick_req.addr  = d_addr;
      pick_req.wdata = d_wdata;
      pick_req.be    = d_be;
    end else begin
      pick_req.we    = 1'b0;
      pick_req.addr  = if_addr;
      pick_req.wdata = '0;
      pick_req.be    = '1;
    end
  end

  always_comb begin
    any_req   = if_req || d_req;
    resp_fire = (state_q == ARB_WAIT) && mem_rvalid;
    state_d   = state_q;
    owner_d   = owner_q;
    req_d     = req_q;
    pick_en   = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          pick_en = 1'b1;
          owner_d = pick_owner;
          req_d   = pick_req;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) begin
          if_gnt  = (owner_q == OWN_IF);
          d_gnt   = (owner_q == OWN_D);
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (resp_fire) begin
          if_rvalid = (owner_q == OWN_IF);
          d_rvalid  = (owner_q == OWN_D);
          if_rdata  = (owner_q == OWN_IF) ? mem_rdata : '0;
          d_rdata   = (owner_q == OWN_D) ? mem_rdata : '0;
          // Re-arbitrate in the response cycle so a waiting requester issues back-to-back.
          if (any_req) begin
            pick_en = 1'b1;
            owner_d = pick_owner;
            req_d   = pick_req;
            state_d = ARB_ISSUE;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = (state_q == ARB_ISSUE);
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic checked through per-requester
// scoreboards against a word-addressed reference memory.
module tb_mem_port_arbiter;

  localparam int SM    = 4;
  localparam int N_TXN = 60;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int rsp_count = 0;
  bit rand_mode = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] mem_arr[int unsigned];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [159:0] all_outs();
    return {21'd0, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy};
  endfunction

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // ---------------- random-phase memory responder ----------------
  initial begin
    bit acc, rv, pend, c_we;
    logic [31:0] c_addr, c_wdata, resp;
    logic [3:0] c_be;
    int lat;
    pend = 0; lat = 0; resp = 0;
    forever begin
      @(negedge clk);
      acc = mem_req && mem_ready; rv = mem_rvalid;
      c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be;
      @(posedge clk);
      #1;
      if (!rand_mode) begin
        pend = 0;
      end else begin
        if (rv) pend = 0;
        if (acc) begin
          pend = 1;
          lat = $urandom_range(0, 3);
          if (c_we) begin
            mem_arr[c_addr] = merge(mem_arr.exists(c_addr) ? mem_arr[c_addr] : init_word(c_addr), c_wdata, c_be);
            resp = 32'd0;
          end else begin
            resp = mem_arr.exists(c_addr) ? mem_arr[c_addr] : init_word(c_addr);
          end
        end
        if (pend) begin
          if (lat == 0) begin
            mem_rvalid = 1; mem_rdata = resp;
          end else begin
            lat--; mem_rvalid = 0; mem_rdata = $urandom;
          end
        end else begin
          mem_rvalid = ($urandom_range(0, 7) == 0);
          mem_rdata  = $urandom;
        end
        mem_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit if_pend, d_pend;
    logic [31:0] exp;
    if_pend = 0; d_pend = 0;
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        if (if_pend && !if_req) check_output("if_req_dropped", 0, 1);
        if (d_pend && !d_req)   check_output("d_req_dropped", 0, 1);
        if_pend = if_req && !if_gnt;
        d_pend  = d_req && !d_gnt;
        if (if_rvalid) begin
          rsp_count++;
          check_output("if_rvalid_excl", {d_rvalid, d_rdata}, 0);
          if (if_q.size() == 0) check_output("if_unexpected_rsp", 1, 0);
          else begin
            exp = if_q.pop_front();
            check_output("if_rdata", if_rdata, exp);
          end
        end
        if (d_rvalid) begin
          rsp_count++;
          check_output("d_rvalid_excl", {if_rvalid, if_rdata}, 0);
          if (d_q.size() == 0) check_output("d_unexpected_rsp", 1, 0);
          else begin
            exp = d_q.pop_front();
            check_output("d_rdata", d_rdata, exp);
          end
        end
      end else begin
        if_pend = 0; d_pend = 0;
      end
    end
  end

  task automatic fetch_requester();
    int guard;
    for (int i = 0; i < N_TXN; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if_req  = 1;
      if_q.push_back(init_word(if_addr));
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!if_gnt && guard < 300);
      if (!if_gnt) check_output("if_gnt_timeout", 0, 1);
      tick();
      if_req = 0;
    end
  endtask

  task automatic data_requester();
    int guard;
    logic [31:0] a, old;
    for (int i = 0; i < N_TXN; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 32'h2000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d_addr = a; d_we = $urandom_range(0, 1); d_wdata = $urandom; d_be = 4'($urandom);
      old = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      if (d_we) begin
        ref_mem[a] = merge(old, d_wdata, d_be);
        d_q.push_back(32'd0);
      end else begin
        d_q.push_back(old);
      end
      d_req = 1;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!d_gnt && guard < 300);
      if (!d_gnt) check_output("d_gnt_timeout", 0, 1);
      tick();
      d_req = 0;
    end
  endtask

  task automatic apply_stimulus();
    bit g_fetch[10];
    int ng, guard;

    // reset state
    clear_inputs();
    reset = 0;
    @(negedge clk); @(negedge clk);
    check_output("reset_outputs", all_outs(), 0);
    tick(); reset = 1;

    // single fetch
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    @(negedge clk); check_output("fetch_c0_idle", {mem_req, busy}, 0);
    tick();
    @(negedge clk); check_output("fetch_c1_issue", {mem_req, mem_we, mem_addr, if_gnt, d_gnt}, {1'b1, 1'b0, 32'h100, 1'b1, 1'b0});
    tick(); if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    @(negedge clk); check_output("fetch_c2_rsp", {if_rvalid, if_rdata, d_rvalid, busy}, {1'b1, 32'h00500093, 1'b0, 1'b1});
    tick(); mem_rvalid = 0;
    @(negedge clk); check_output("fetch_c3_idle", busy, 0);

    // simultaneous fetch and load: data first, fetch back-to-back
    tick(); if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000; mem_ready = 1;
    tick();
    @(negedge clk); check_output("both_c1_data", {mem_addr, d_gnt, if_gnt}, {32'h2000, 1'b1, 1'b0});
    tick(); d_req = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
    @(negedge clk); check_output("both_c2_drsp", {d_rvalid, d_rdata, if_rvalid, if_rdata}, {1'b1, 32'h11112222, 1'b0, 32'h0});
    tick(); mem_rvalid = 0;
    @(negedge clk); check_output("both_c3_fetch", {mem_req, mem_addr, if_gnt, busy}, {1'b1, 32'h104, 1'b1, 1'b1});
    tick(); if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    @(negedge clk); check_output("both_c4_irsp", {if_rvalid, if_rdata}, {1'b1, 32'hCAFE0001});
    tick(); mem_rvalid = 0;

    // starvation bound: continuous data traffic with a fetch waiting
    tick(); if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h2004;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 0;
    ng = 0; guard = 0;
    while (ng < 10 && guard < 60) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        check_output("gnt_onehot", {if_gnt, d_gnt} == 2'b11, 0);
        g_fetch[ng] = if_gnt;
        ng++;
      end
      guard++;
      if (ng < 10) tick();
    end
    if (ng < 10) check_output("starve_timeout", ng, 10);
    for (int k = 0; k < ng; k++)
      check_output($sformatf("starve_gnt%0d", k), g_fetch[k], (k % (SM + 1)) == SM);
    tick(); if_req = 0; d_req = 0;
    guard = 0;
    do begin @(negedge clk); guard++; if (busy) tick(); end while (busy && guard < 20);
    check_output("starve_drain", busy, 0);
    tick(); mem_ready = 0; mem_rvalid = 0;

    // store with 5-cycle stall in ISSUE
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output($sformatf("stall_c%0d", c), {mem_req, mem_we, mem_addr, mem_wdata, mem_be, d_gnt, if_gnt},
                   {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b0});
      tick();
    end
    mem_ready = 1;
    @(negedge clk); check_output("store_gnt", {d_gnt, mem_we, mem_addr}, {1'b1, 1'b1, 32'h40});
    tick(); d_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 0;
    @(negedge clk); check_output("store_ack", {d_rvalid, if_rvalid}, {1'b1, 1'b0});
    tick(); mem_rvalid = 0;
    @(negedge clk); check_output("store_idle", busy, 0);

    // reset mid-WAIT aborts the transaction
    tick(); if_req = 1; if_addr = 32'h300; mem_ready = 1;
    tick();
    @(negedge clk); check_output("rst_gnt", if_gnt, 1);
    tick(); if_req = 0; mem_ready = 0; reset = 0;
    @(negedge clk); check_output("rst_outputs", all_outs(), 0);
    tick(); reset = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); check_output("rst_stale_rvalid", all_outs(), 0);
    tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h304; mem_ready = 1;
    tick();
    @(negedge clk); check_output("rst_refetch_gnt", {if_gnt, mem_addr}, {1'b1, 32'h304});
    tick(); if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00000013;
    @(negedge clk); check_output("rst_refetch_rsp", {if_rvalid, if_rdata}, {1'b1, 32'h13});
    tick(); mem_rvalid = 0;
    tick();

    // randomized traffic
    rand_mode = 1;
    fork
      fetch_requester();
      data_requester();
    join
    guard = 0;
    do begin @(negedge clk); guard++; end
    while ((if_q.size() != 0 || d_q.size() != 0 || busy) && guard < 500);
    check_output("rand_drain", {if_q.size() != 0, d_q.size() != 0, busy}, 0);
    check_output("rand_rsp_count", rsp_count, 2 * N_TXN);
    rand_mode = 0;
  endtask

  initial begin
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
